// File: rtl/rr_arbiter_8to3_if.sv
// ----------------------------------------------------------------------------
// rr_arbiter_8to3_if
// Bundle of the request/grant signals between the requesting blocks and the
// 8-to-3 round-robin arbiter. Clock and reset are not part of the bundle.
//
// Signals:
//   req      [7:0]  request vector, bit i = requester i
//   rel             release strobe from the current owner
//   gnt      [7:0]  one-hot grant (registered in the arbiter)
//   gnt_idx  [2:0]  binary index of the granted requester (registered)
//   gnt_vld         high while a grant is held
//   req_pend        some request other than the granted one is pending
//   tmo             one-cycle pulse on a forced (timeout) release
//
// Modports:
//   master  requester side: drives req/rel, observes the grant outputs
//   slave   arbiter side: observes req/rel, drives the grant outputs
// ----------------------------------------------------------------------------
interface rr_arbiter_8to3_if;
    logic [7:0] req;
    logic       rel;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       gnt_vld;
    logic       req_pend;
    logic       tmo;

    modport master (
        output req,
        output rel,
        input  gnt,
        input  gnt_idx,
        input  gnt_vld,
        input  req_pend,
        input  tmo
    );

    modport slave (
        input  req,
        input  rel,
        output gnt,
        output gnt_idx,
        output gnt_vld,
        output req_pend,
        output tmo
    );
endinterface

// File: rtl/rr_arbiter_8to3.sv
// ----------------------------------------------------------------------------
// rr_arbiter_8to3
// Round-robin arbiter sharing one resource among 8 requesters. The winner is
// the first requester found scanning from the priority pointer upward with
// wrap-around. A grant is held until the owner pulses rel or drops its
// request; after every grant there is exactly one IDLE cycle, and the pointer
// moves to one past the released owner so that owner ranks lowest next time.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   When defined, a hold counter forces a release after MAX_HOLD grant cycles
//   and pulses tmo for one cycle. When undefined, grants are held
//   indefinitely and tmo is constant 0.
//
// Parameters:
//   MAX_HOLD  maximum grant duration in cycles (2..255), used only with
//             ARB_TIMEOUT_EN
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous, active-high reset (priority over all other inputs)
//   bus   rr_arbiter_8to3_if.slave: req, rel in; gnt, gnt_idx, gnt_vld,
//         req_pend, tmo out
// ----------------------------------------------------------------------------
module rr_arbiter_8to3 #(
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_arbiter_8to3_if.slave        bus
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Elaboration-time range check on the hold limit.
    if ((MAX_HOLD < 2) || (MAX_HOLD > 255)) begin : g_bad_max_hold
        $error("rr_arbiter_8to3: MAX_HOLD must be within 2..255");
    end

    state_t     state_q,   state_d;
    logic [7:0] gnt_q,     gnt_d;
    logic [2:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic       tmo_q,     tmo_d;
    logic [2:0] ptr_q,     ptr_d;

    logic       win_found_s;
    logic [2:0] win_idx_s;
    logic [2:0] cand_s;
    logic       win_hit_s;
    logic       rel_norm_s;
    logic       tmo_hit_s;

`ifdef ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [7:0] cnt_q, cnt_d;
`endif

    // Rotating-priority search: first set request at ptr, ptr+1, ... (mod 8).
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = 3'd0;
        cand_s      = 3'd0;
        win_hit_s   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            // 3-bit addition wraps naturally, giving the mod-8 scan order.
            cand_s      = ptr_q + 3'(i);
            win_hit_s   = ~win_found_s & bus.req[cand_s];
            win_idx_s   = win_hit_s ? cand_s : win_idx_s;
            win_found_s = win_found_s | win_hit_s;
        end
    end

    // Release conditions seen while a grant is held.
    always_comb begin
        // rel and a dropped owner request together still count as one release.
        rel_norm_s = bus.rel | ~bus.req[gnt_idx_q];
`ifdef ARB_TIMEOUT_EN
        tmo_hit_s  = (cnt_q == HOLD_LAST);
`else
        tmo_hit_s  = 1'b0;
`endif
    end

    // Next-state and next-output logic of the IDLE/GRANT machine.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        ptr_d     = ptr_q;
        tmo_d     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    gnt_d     = 8'd1 << win_idx_s;
                    gnt_idx_d = win_idx_s;
                    gnt_vld_d = 1'b1;
                    state_d   = ST_GRANT;
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = 8'd0;
`endif
                end else begin
                    gnt_d     = 8'd0;
                    gnt_vld_d = 1'b0;
                end
            end
            ST_GRANT: begin
                if (rel_norm_s || tmo_hit_s) begin
                    // gnt_idx keeps its value for downstream mux stability.
                    gnt_d     = 8'd0;
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + 3'd1;
                    state_d   = ST_IDLE;
                    // A normal release wins over a coincident timeout.
                    tmo_d     = tmo_hit_s & ~rel_norm_s;
                end else begin
`ifdef ARB_TIMEOUT_EN
                    cnt_d     = cnt_q + 8'd1;
`endif
                end
            end
            default: begin
                gnt_d     = 8'd0;
                gnt_vld_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, grant and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gnt_q     <= 8'd0;
            gnt_idx_q <= 3'd0;
            gnt_vld_q <= 1'b0;
            tmo_q     <= 1'b0;
            ptr_q     <= 3'd0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
            tmo_q     <= tmo_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.gnt      = gnt_q;
    assign bus.gnt_idx  = gnt_idx_q;
    assign bus.gnt_vld  = gnt_vld_q;
    assign bus.tmo      = tmo_q;
    assign bus.req_pend = |(bus.req & ~gnt_q);

endmodule

// File: tb/tb_rr_arbiter_8to3.sv
// ----------------------------------------------------------------------------
// tb_rr_arbiter_8to3
// Directed self-checking bench for rr_arbiter_8to3. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising edge.
// ----------------------------------------------------------------------------
module tb_rr_arbiter_8to3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rr_arbiter_8to3_if bus_if ();

    rr_arbiter_8to3 #(.MAX_HOLD(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [7:0] g, input logic [2:0] idx,
                             input logic vld);
        chk({tag, ".gnt"}, bus_if.gnt, g);
        chk({tag, ".idx"}, 8'(bus_if.gnt_idx), 8'(idx));
        chk({tag, ".vld"}, 8'(bus_if.gnt_vld), 8'(vld));
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst        = 1'b1;
        bus_if.req = 8'hFF;
        bus_if.rel = 1'b0;
        @(negedge clk);

        // Reset for two cycles with all requests high.
        tick();
        tick();
        chk_grant("reset", 8'h00, 3'd0, 1'b0);
        chk("reset.tmo", 8'(bus_if.tmo), 8'd0);
        chk("reset.pend", 8'(bus_if.req_pend), 8'd1);

        // First edge after reset grants requester 0.
        rst = 1'b0;
        tick();
        chk_grant("first", 8'h01, 3'd0, 1'b1);
        chk("first.pend", 8'(bus_if.req_pend), 8'd1);

        // Full rotation with one IDLE cycle between grants.
        for (int k = 0; k < 8; k++) begin
            bus_if.rel = 1'b1;
            tick();
            chk_grant($sformatf("rot%0d.idle", k), 8'h00, 3'(k), 1'b0);
            bus_if.rel = 1'b0;
            tick();
            chk_grant($sformatf("rot%0d.gnt", k), 8'd1 << ((k + 1) % 8), 3'((k + 1) % 8), 1'b1);
        end

        // Move the grant to requester 5 (ptr becomes 1 after releasing 0).
        bus_if.req = 8'h20;
        bus_if.rel = 1'b1;
        tick();
        chk_grant("to5.idle", 8'h00, 3'd0, 1'b0);
        bus_if.rel = 1'b0;
        tick();
        chk_grant("to5.gnt", 8'h20, 3'd5, 1'b1);

        // Release 5 with req 0,2,5 pending: scan 6,7,0 gives 0.
        bus_if.req = 8'b0010_0101;
        bus_if.rel = 1'b1;
        tick();
        chk_grant("prio.idle", 8'h00, 3'd5, 1'b0);
        bus_if.rel = 1'b0;
        tick();
        chk_grant("prio.win0", 8'h01, 3'd0, 1'b1);
        bus_if.rel = 1'b1;
        tick();
        chk_grant("prio.idle2", 8'h00, 3'd0, 1'b0);
        bus_if.rel = 1'b0;
        tick();
        chk_grant("prio.win2", 8'h04, 3'd2, 1'b1);

        // Dropping req[2] releases; then requester 3 is granted.
        bus_if.req = 8'h08;
        tick();
        chk_grant("drop2.idle", 8'h00, 3'd2, 1'b0);
        tick();
        chk_grant("grant3", 8'h08, 3'd3, 1'b1);

        // Toggling req[6] during the grant: grant unchanged, req_pend follows.
        bus_if.req = 8'h48;
        tick();
        chk_grant("tog6.on", 8'h08, 3'd3, 1'b1);
        chk("tog6.pend_on", 8'(bus_if.req_pend), 8'd1);
        bus_if.req = 8'h08;
        tick();
        chk_grant("tog6.off", 8'h08, 3'd3, 1'b1);
        chk("tog6.pend_off", 8'(bus_if.req_pend), 8'd0);

        // Drop req[3]: release next cycle.
        bus_if.req = 8'h00;
        tick();
        chk_grant("drop3", 8'h00, 3'd3, 1'b0);

        // rel while IDLE is ignored.
        bus_if.rel = 1'b1;
        tick();
        chk_grant("idle_rel", 8'h00, 3'd3, 1'b0);
        bus_if.rel = 1'b0;

        // ptr is 4: with req 3 and 4 pending, 4 wins.
        bus_if.req = 8'h18;
        tick();
        chk_grant("grant4", 8'h10, 3'd4, 1'b1);

        // Reset mid-grant.
        rst        = 1'b1;
        bus_if.req = 8'h90;
        tick();
        chk_grant("midrst", 8'h00, 3'd0, 1'b0);
        chk("midrst.tmo", 8'(bus_if.tmo), 8'd0);
        rst = 1'b0;
        tick();
        chk_grant("post_rst", 8'h10, 3'd4, 1'b1);

        // Release 4 (ptr=5), then reset must bring ptr back to 0.
        bus_if.rel = 1'b1;
        tick();
        chk_grant("rel4", 8'h00, 3'd4, 1'b0);
        bus_if.rel = 1'b0;
        rst        = 1'b1;
        bus_if.req = 8'h81;
        tick();
        rst = 1'b0;
        tick();
        chk_grant("ptr_rst", 8'h01, 3'd0, 1'b1);

        // Release 0 (ptr=1), then request only 2.
        bus_if.req = 8'h04;
        tick();
        chk_grant("pre_hold.idle", 8'h00, 3'd0, 1'b0);
        tick();
        chk_grant("hold.gnt", 8'h04, 3'd2, 1'b1);
        chk("hold.tmo0", 8'(bus_if.tmo), 8'd0);

`ifdef ARB_TIMEOUT_EN
        // MAX_HOLD=4: grant visible for 4 cycles, then forced release.
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_grant($sformatf("tmo.hold%0d", k), 8'h04, 3'd2, 1'b1);
            chk($sformatf("tmo.hold%0d.tmo", k), 8'(bus_if.tmo), 8'd0);
        end
        bus_if.req = 8'h0C;
        tick();
        chk_grant("tmo.rel", 8'h00, 3'd2, 1'b0);
        chk("tmo.pulse", 8'(bus_if.tmo), 8'd1);
        // ptr=3 after the forced release: requester 3 wins over 2.
        tick();
        chk_grant("tmo.ptr3", 8'h08, 3'd3, 1'b1);
        chk("tmo.pulse_end", 8'(bus_if.tmo), 8'd0);
        // Normal release in the timeout cycle takes precedence.
        for (int k = 0; k < 3; k++) begin
            tick();
        end
        chk_grant("tmo.last", 8'h08, 3'd3, 1'b1);
        bus_if.rel = 1'b1;
        tick();
        chk_grant("tmo.coinc", 8'h00, 3'd3, 1'b0);
        chk("tmo.coinc.tmo", 8'(bus_if.tmo), 8'd0);
        bus_if.rel = 1'b0;
`else
        // No timeout: grant held indefinitely, tmo stays low.
        for (int k = 0; k < 55; k++) begin
            tick();
            chk($sformatf("held%0d.vld", k), 8'(bus_if.gnt_vld), 8'd1);
            chk($sformatf("held%0d.gnt", k), bus_if.gnt, 8'h04);
            chk($sformatf("held%0d.tmo", k), 8'(bus_if.tmo), 8'd0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_8to3.md
Name: rr_arbiter_8to3

Overview:
- Round-robin arbiter sharing one resource among 8 requesters.
- Uses a rotating-priority 8-to-3 encoding to select the winner.
- Outputs the grant both one-hot and as a 3-bit index for downstream mux select.
- Sits between requesting blocks and a shared datapath; the grant is held until the owner releases it.

Parameters:
- MAX_HOLD, 16: maximum grant duration in cycles. Used only when ARB_TIMEOUT_EN is defined; legal range 2..255.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; bit i = requester i
- rel  input  1  release strobe from the current owner
- gnt  output  8  one-hot grant, registered
- gnt_idx  output  3  binary index of the granted requester, registered
- gnt_vld  output  1  high while a grant is held
- req_pend  output  1  any non-granted request is high (combinational from req and gnt)
- tmo  output  1  one-cycle pulse on forced release

Behaviour:
- Reset:
  - Applies on any clk edge with rst=1, including mid-grant.
  - Sets gnt=8'h00, gnt_idx=3'd0, gnt_vld=0, tmo=0, priority pointer ptr=3'd0, state=IDLE.
  - Reset has priority over all other inputs.
- State machine, two states:
  - IDLE:
    - If req==0, stay in IDLE with outputs at zero.
    - Otherwise the winner is the first set bit scanning ptr, ptr+1, … , 7, 0, … , ptr-1 (mod 8).
    - Next edge: gnt=one-hot(winner), gnt_idx=winner, gnt_vld=1, state to GRANT.
    - Latency: req at edge t gives a visible grant after edge t+1.
  - GRANT:
    - Outputs are held constant.
    - Changes on other req bits are ignored.
    - Release condition: rel=1, or req[gnt_idx]=0.
    - On release, at the next edge: gnt=0, gnt_idx retains its last value, gnt_vld=0, ptr=gnt_idx+1 mod 8 (7 wraps to 0), state to IDLE.
- Minimum gap: exactly one IDLE cycle between consecutive grants. No back-to-back handover.
- rel while in IDLE is ignored.
- rel and a drop of req[gnt_idx] in the same cycle count as a single release.
- The just-released requester has the lowest priority in the next arbitration. Starvation bound: at most 7 other grants before any continuously asserted request is served.
- req_pend = |(req & ~gnt). Valid in both states.
- gnt is always zero or one-hot. gnt_vld == |gnt at all times.

Optional Feature:
ARB_TIMEOUT_EN
- Defined:
  - An 8-bit hold counter clears on grant and increments each GRANT cycle.
  - When the counter reaches MAX_HOLD-1 without a release, the next edge forces release with the normal ptr update.
  - tmo=1 for that one cycle.
  - A normal release in the same cycle takes precedence; tmo stays 0.
- Undefined: no counter; tmo tied to 0; grants are held indefinitely.

Test Plan:
- Reset behaviour: rst=1 for 2 cycles with req=8'hFF → gnt=0, gnt_vld=0, gnt_idx=0. First edge after rst=0 → gnt=8'h01, gnt_idx=0.
- Full rotation: req=8'hFF held, pulse rel each cycle in GRANT → gnt_idx sequence 0,1,2,…,7,0 with one IDLE cycle between each grant; pointer wraps 7→0.
- Priority after release: hold grant on idx 5, then req=8'b00100101 and rel → next winner idx 0 (scan 6,7,0). Then release → winner idx 2.
- Request drop and ignored inputs: while granted idx 3, drop req[3] → gnt_vld=0 next cycle. rel pulsed while IDLE → no state change. Toggling req[6] during the grant → gnt unchanged, req_pend follows req[6].
- Reset mid-grant: rst=1 while gnt=8'h10 → all outputs zero next edge, ptr=0; req=8'h90 after reset → idx 4.
- Timeout (macro defined, MAX_HOLD=4): req[2] held with no rel → gnt_vld high 4 cycles, tmo=1 on the release edge, ptr=3. Without the macro → grant held 50+ cycles, tmo=0 throughout.
